// File: rtl/vdma_base_addr_pkg.sv
// vdma_base_addr_pkg: FSM state encodings and shift-add step count shared by frame_base_addr.
package vdma_base_addr_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, MUL, OUT} state_t;
    localparam int MUL_STEPS = 3;
    localparam int STEP_W    = 2;
endpackage

// File: rtl/frame_base_addr.sv
// frame_base_addr: per-frame base address BASE_ADDR + idx*FRAME_BYTES via a 3-step serial shift-add.
// Optional sticky overrun output enabled by defining FRAME_OVERRUN_EN.
module frame_base_addr
    import vdma_base_addr_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h1000_0000),
    parameter logic [ADDR_W-1:0] FRAME_BYTES = ADDR_W'(32'h0020_0000),
    parameter int                NUM_BUF     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_sync,
    input  logic [2:0]        idx,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              idx_err,
    output logic [15:0]       frame_cnt
`ifdef FRAME_OVERRUN_EN
    ,
    output logic              overrun
`endif
);
    state_t              r_state, w_next;
    logic [STEP_W-1:0]   r_step;
    logic [2:0]          r_idx;
    logic [ADDR_W-1:0]   r_acc, r_addr, w_sum;
    logic                r_err, w_idx_bad, w_last;
    logic [15:0]         r_cnt;

    assign w_idx_bad = int'(idx) >= NUM_BUF;
    assign w_last    = r_step == STEP_W'(MUL_STEPS - 1);
    assign w_sum     = r_acc + (r_idx[r_step] ? (FRAME_BYTES << r_step) : '0);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = frame_sync ? WAIT : IDLE;
            WAIT:    w_next = MUL;
            MUL:     w_next = w_last ? OUT : MUL;
            OUT:     w_next = addr_ready ? IDLE : OUT;
            default: w_next = IDLE;
        endcase
    end

    // idx is sampled in WAIT because the upstream encoder lags frame_sync by a cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step <= '0;
            r_idx  <= '0;
            r_acc  <= '0;
            r_addr <= BASE_ADDR;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_err <= (r_state == WAIT) && w_idx_bad;
            if (r_state == WAIT) begin
                r_idx  <= w_idx_bad ? 3'd0 : idx;
                r_acc  <= BASE_ADDR;
                r_step <= '0;
            end
            if (r_state == MUL) begin
                r_acc  <= w_sum;
                r_step <= r_step + 1'b1;
                if (w_last) r_addr <= w_sum;
            end
            if (r_state == OUT && addr_ready) r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef FRAME_OVERRUN_EN
    logic r_ovr;
    always_ff @(posedge clk) begin
        if (rst)                               r_ovr <= 1'b0;
        else if (frame_sync && r_state != IDLE) r_ovr <= 1'b1;
    end
    assign overrun = r_ovr;
`endif

    assign addr_valid = r_state == OUT;
    assign busy       = r_state != IDLE;
    assign addr       = r_addr;
    assign idx_err    = r_err;
    assign frame_cnt  = r_cnt;
endmodule

// File: tb/tb_frame_base_addr.sv
// tb_frame_base_addr: table-driven and randomized checks of frame_base_addr against an arithmetic model,
// with a second instance exercising address wrap-around.
module tb_frame_base_addr;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_sync = 1'b0;
    logic [2:0]  idx = 3'd0;
    logic        addr_ready = 1'b0;
    logic        addr_valid, busy, idx_err;
    logic [31:0] addr;
    logic [15:0] frame_cnt;
    logic        w_addr_valid, w_busy, w_idx_err;
    logic [31:0] w_addr;
    logic [15:0] w_frame_cnt;
`ifdef FRAME_OVERRUN_EN
    logic        overrun, w_overrun;
`endif

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;
    bit exp_ovr = 1'b0;

    always #5 clk = ~clk;

    frame_base_addr u_dut (
        .clk(clk), .rst(rst), .frame_sync(frame_sync), .idx(idx),
        .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr),
        .busy(busy), .idx_err(idx_err), .frame_cnt(frame_cnt)
`ifdef FRAME_OVERRUN_EN
        , .overrun(overrun)
`endif
    );

    frame_base_addr #(.BASE_ADDR(32'hFFF0_0000), .FRAME_BYTES(32'h0020_0000)) u_wrap (
        .clk(clk), .rst(rst), .frame_sync(frame_sync), .idx(idx),
        .addr_valid(w_addr_valid), .addr_ready(addr_ready), .addr(w_addr),
        .busy(w_busy), .idx_err(w_idx_err), .frame_cnt(w_frame_cnt)
`ifdef FRAME_OVERRUN_EN
        , .overrun(w_overrun)
`endif
    );

    typedef struct {
        logic [2:0]  idx;
        int          delay;
        bit          fs_extra;
        logic [31:0] exp_addr;
        logic [31:0] exp_waddr;
        bit          exp_err;
    } vec_t;

    function automatic logic [31:0] model_addr(input logic [31:0] base, input logic [2:0] v);
        int eff = (v < 5) ? int'(v) : 0;
        return base + 32'h0020_0000 * eff;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ovr();
`ifdef FRAME_OVERRUN_EN
        chk("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
`endif
    endtask

    task automatic txn(input logic [2:0] v, input int delay, input bit fs_extra,
                       input logic [31:0] ea, input logic [31:0] ewa, input bit eerr);
        addr_ready = (delay == 0);
        frame_sync = 1'b1;
        idx = ~v;
        step();
        frame_sync = 1'b0;
        idx = v;
        chk("busy_c1", {31'd0, busy}, 32'd1);
        chk("valid_c1", {31'd0, addr_valid}, 32'd0);
        step();
        idx = 3'($urandom);
        chk("idx_err", {31'd0, idx_err}, {31'd0, eerr});
        step();
        chk("idx_err_once", {31'd0, idx_err}, 32'd0);
        frame_sync = fs_extra;
        step();
        frame_sync = 1'b0;
        chk("valid_c4", {31'd0, addr_valid}, 32'd0);
        step();
        chk("valid_c5", {31'd0, addr_valid}, 32'd1);
        chk("addr", addr, ea);
        chk("wrap_addr", w_addr, ewa);
        repeat (delay) begin
            step();
            chk("hold_valid", {31'd0, addr_valid}, 32'd1);
            chk("hold_addr", addr, ea);
        end
        addr_ready = 1'b1;
        frame_sync = fs_extra;
        step();
        addr_ready = 1'b0;
        frame_sync = 1'b0;
        exp_cnt = (exp_cnt + 1) & 16'hFFFF;
        if (fs_extra) exp_ovr = 1'b1;
        chk("valid_after_hs", {31'd0, addr_valid}, 32'd0);
        chk("busy_after_hs", {31'd0, busy}, 32'd0);
        chk("frame_cnt", {16'd0, frame_cnt}, exp_cnt[31:0]);
        chk("addr_held", addr, ea);
        chk_ovr();
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{3'd0, 0,  1'b0, 32'h1000_0000, 32'hFFF0_0000, 1'b0};
        vecs[1] = '{3'd4, 0,  1'b0, 32'h1080_0000, 32'h0070_0000, 1'b0};
        vecs[2] = '{3'd7, 1,  1'b0, 32'h1000_0000, 32'hFFF0_0000, 1'b1};
        vecs[3] = '{3'd3, 10, 1'b0, 32'h1060_0000, 32'h0050_0000, 1'b0};
        vecs[4] = '{3'd1, 2,  1'b1, 32'h1020_0000, 32'h0010_0000, 1'b0};
        vecs[5] = '{3'd5, 0,  1'b0, 32'h1000_0000, 32'hFFF0_0000, 1'b1};

        step();
        step();
        chk("rst_valid", {31'd0, addr_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_idx_err", {31'd0, idx_err}, 32'd0);
        chk("rst_addr", addr, 32'h1000_0000);
        chk("rst_wrap_addr", w_addr, 32'hFFF0_0000);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk_ovr();
        rst = 1'b0;
        addr_ready = 1'b1;
        step();
        step();
        chk("idle_ready_no_effect", {16'd0, frame_cnt}, 32'd0);

        for (int i = 0; i < 6; i++)
            txn(vecs[i].idx, vecs[i].delay, vecs[i].fs_extra,
                vecs[i].exp_addr, vecs[i].exp_waddr, vecs[i].exp_err);

        step();
        step();
        chk("no_second_txn", {31'd0, busy}, 32'd0);
        chk_ovr();

        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        idx = 3'd2;
        step();
        step();
        rst = 1'b1;
        frame_sync = 1'b1;
        addr_ready = 1'b1;
        step();
        rst = 1'b0;
        frame_sync = 1'b0;
        addr_ready = 1'b0;
        exp_cnt = 0;
        exp_ovr = 1'b0;
        chk("midmul_rst_valid", {31'd0, addr_valid}, 32'd0);
        chk("midmul_rst_busy", {31'd0, busy}, 32'd0);
        chk("midmul_rst_addr", addr, 32'h1000_0000);
        chk("midmul_rst_cnt", {16'd0, frame_cnt}, 32'd0);
        chk_ovr();
        step();
        chk("rst_priority_idle", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] v;
            bit e;
            v = 3'($urandom_range(0, 7));
            e = v >= 3'd5;
            txn(v, int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                model_addr(32'h1000_0000, v), model_addr(32'hFFF0_0000, v), e);
            if ($urandom_range(0, 1) == 1) step();
        end

        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_ovr = 1'b0;
        chk_ovr();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
